// File: rtl/mem_burst_pkg.sv
// Shared widths, types and state encoding for the 4x64-bit burst memory responder.
package mem_burst_pkg;

    localparam int unsigned BURST_BEATS = 4;
    localparam int unsigned BEAT_W      = 64;
    localparam int unsigned LINE_W      = BURST_BEATS * BEAT_W;

    typedef logic [BEAT_W-1:0] beat_t;
    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        DONE
    } resp_state_e;

    // Beat k of a line, little-endian beat order (beat 0 = bits [63:0]).
    function automatic beat_t get_beat(input line_t line, input logic [1:0] k);
        return line[BEAT_W*k +: BEAT_W];
    endfunction

endpackage

// File: rtl/burst_line_ram.sv
// Line-addressed storage: synchronous write with synchronous clear, combinational line read.
module burst_line_ram
    import mem_burst_pkg::*;
#(
    parameter int unsigned NUM_LINES = 16,
    parameter int unsigned IDX_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [LINE_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [LINE_W-1:0] rdata
);

    line_t mem_q [NUM_LINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_LINES); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/burst_memory_responder.sv
// Memory-side responder: accepts a line request, waits LATENCY cycles, then streams or
// absorbs four 64-bit beats. Write data is staged and committed atomically on the last beat.
module burst_memory_responder
    import mem_burst_pkg::*;
#(
    parameter int unsigned LATENCY   = 8,
    parameter int unsigned NUM_LINES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [31:0]       address_i,
    input  logic [BEAT_W-1:0] burst_i,
    output logic [BEAT_W-1:0] burst_o,
    output logic              resp_o,
    output logic              err_o
);

    localparam int unsigned IDX_W    = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam logic [7:0]  LAT_INIT = 8'(LATENCY - 1);

    resp_state_e      state_q, state_d;
    logic             op_write_q, op_write_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       lat_q, lat_d;
    logic [1:0]       beat_q, beat_d;
    line_t            rd_buf_q, rd_buf_d;
    line_t            stage_q, stage_d;
    beat_t            last_q, last_d;
    logic             err_q, err_d;

    logic             ram_we;
    line_t            ram_wdata;
    line_t            ram_rdata;
    logic [IDX_W-1:0] req_idx;

    // Upper address bits alias onto the same lines; byte offset is meaningless at line grain.
    logic unused_addr;
    assign unused_addr = ^{address_i[31:5+IDX_W], address_i[4:0]};

    assign req_idx = address_i[5 +: IDX_W];

    burst_line_ram #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (idx_q),
        .wdata (ram_wdata),
        .raddr (req_idx),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_write_q <= 1'b0;
            idx_q      <= '0;
            lat_q      <= '0;
            beat_q     <= '0;
            rd_buf_q   <= '0;
            stage_q    <= '0;
            last_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_write_q <= op_write_d;
            idx_q      <= idx_d;
            lat_q      <= lat_d;
            beat_q     <= beat_d;
            rd_buf_q   <= rd_buf_d;
            stage_q    <= stage_d;
            last_q     <= last_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_write_d = op_write_q;
        idx_d      = idx_q;
        lat_d      = lat_q;
        beat_d     = beat_q;
        rd_buf_d   = rd_buf_q;
        stage_d    = stage_q;
        last_d     = last_q;
        err_d      = err_q;
        ram_we     = 1'b0;
        ram_wdata  = stage_q;
        resp_o     = 1'b0;
        burst_o    = last_q;

        case (state_q)
            IDLE: begin
                if (read_i && write_i) begin
                    err_d = 1'b1;
                end else if (read_i || write_i) begin
                    op_write_d = write_i;
                    idx_d      = req_idx;
                    rd_buf_d   = ram_rdata;
                    lat_d      = LAT_INIT;
                    beat_d     = '0;
                    state_d    = (LATENCY <= 1) ? BURST : WAIT;
                end
            end
            WAIT: begin
                lat_d = lat_q - 8'd1;
                if (lat_q == 8'd1) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                resp_o = 1'b1;
                beat_d = beat_q + 2'd1;
                if (op_write_q) begin
                    stage_d[BEAT_W*beat_q +: BEAT_W] = burst_i;
                    if (beat_q == 2'd3) begin
                        ram_we    = 1'b1;
                        ram_wdata = stage_d;
                    end
                end else begin
                    burst_o = get_beat(rd_buf_q, beat_q);
                    last_d  = burst_o;
                end
                if (beat_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_burst_memory_responder.sv
// Bench for burst_memory_responder: three instances (LATENCY 8, 1, 20) checked against a
// line-array model with randomized lines and addresses.
module tb_burst_memory_responder;
    import mem_burst_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        read_i    [3];
    logic        write_i   [3];
    logic [31:0] address_i [3];
    logic [63:0] burst_i   [3];
    logic [63:0] burst_o   [3];
    logic        resp_o    [3];
    logic        err_o     [3];

    line_t model [3][16];
    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        burst_memory_responder #(
            .LATENCY   ((g == 0) ? 8 : ((g == 1) ? 1 : 20)),
            .NUM_LINES (16)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .read_i    (read_i[g]),
            .write_i   (write_i[g]),
            .address_i (address_i[g]),
            .burst_i   (burst_i[g]),
            .burst_o   (burst_o[g]),
            .resp_o    (resp_o[g]),
            .err_o     (err_o[g])
        );
    end

    function automatic int exp_lat(input int d);
        return (d == 0) ? 8 : ((d == 1) ? 1 : 20);
    endfunction

    function automatic line_t rand_line();
        line_t l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    function automatic void clear_model();
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 16; i++) model[d][i] = '0;
    endfunction

    // Drives one transaction on instance d and records what the DUT did; no judging here.
    task automatic run_txn(input int d, input bit rd, input bit wr, input logic [31:0] addr,
                           input line_t wdata, input bit drop_early, output line_t rdata,
                           output int lat, output int beats, output bit gap_ok);
        int c;
        bit seen;
        rdata  = '0;
        lat    = -1;
        beats  = 0;
        gap_ok = 1'b0;
        seen   = 1'b0;
        c      = 0;
        @(negedge clk);
        read_i[d]    = rd;
        write_i[d]   = wr;
        address_i[d] = addr;
        @(posedge clk);
        while (c < 400) begin
            @(negedge clk);
            c++;
            if (drop_early || resp_o[d]) begin
                read_i[d]    = 1'b0;
                write_i[d]   = 1'b0;
                address_i[d] = $urandom;
            end
            if (resp_o[d]) begin
                if (!seen) begin
                    seen = 1'b1;
                    lat  = c;
                end
                if (beats < 4) begin
                    rdata[64*beats +: 64] = burst_o[d];
                    burst_i[d]            = wdata[64*beats +: 64];
                end
                beats++;
            end else if (seen) begin
                gap_ok = 1'b1;
                break;
            end
        end
        burst_i[d] = {$urandom, $urandom};
        if (wr && !rd) model[d][addr[8:5]] = wdata;
    endtask

    task automatic test_reset();
        line_t rdata;
        int lat, beats;
        bit gap;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            compared++;
            if (resp_o[d] !== 1'b0 || burst_o[d] !== 64'h0 || err_o[d] !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_outputs inst%0d: resp=%b burst=%h err=%b, required 0/0/0",
                         d, resp_o[d], burst_o[d], err_o[d]);
            end
        end
        rst = 1'b0;
        clear_model();
        run_txn(0, 1'b1, 1'b0, 32'h40, '0, 1'b0, rdata, lat, beats, gap);
        compared++;
        if (lat !== 8) begin
            mismatched++;
            $display("FAIL reset_read_latency: got %0d, required 8", lat);
        end
        compared++;
        if (rdata !== '0 || beats !== 4 || !gap) begin
            mismatched++;
            $display("FAIL reset_read_data: data=%h beats=%0d gap=%b, required 0/4/1",
                     rdata, beats, gap);
        end
    endtask

    task automatic test_write_read();
        line_t wl, rdata;
        int lat, beats;
        bit gap;
        wl = {64'h4444444444444444, 64'h3333333333333333,
              64'h2222222222222222, 64'h1111111111111111};
        run_txn(0, 1'b0, 1'b1, 32'h60, wl, 1'b0, rdata, lat, beats, gap);
        compared++;
        if (lat !== 8 || beats !== 4 || !gap) begin
            mismatched++;
            $display("FAIL write_shape: lat=%0d beats=%0d gap=%b, required 8/4/1", lat, beats, gap);
        end
        run_txn(0, 1'b1, 1'b0, 32'h60, '0, 1'b0, rdata, lat, beats, gap);
        compared++;
        if (rdata !== wl || beats !== 4 || !gap) begin
            mismatched++;
            $display("FAIL write_read_data: got %h beats=%0d gap=%b, required %h/4/1",
                     rdata, beats, gap, wl);
        end
    endtask

    // Random reads/writes across all three instances, issued back to back.
    task automatic test_back_to_back();
        line_t wl, rdata;
        int lat, beats, d;
        bit gap, wr;
        logic [31:0] addr;
        for (int n = 0; n < 24; n++) begin
            d    = $urandom_range(0, 2);
            wr   = $urandom_range(0, 1) == 1;
            addr = $urandom;
            wl   = rand_line();
            if (!wr) wl = model[d][addr[8:5]];
            run_txn(d, !wr, wr, addr, wr ? wl : rand_line(), 1'b0, rdata, lat, beats, gap);
            compared++;
            if (lat !== exp_lat(d) || beats !== 4 || !gap) begin
                mismatched++;
                $display("FAIL b2b_shape[%0d] inst%0d: lat=%0d beats=%0d gap=%b, required %0d/4/1",
                         n, d, lat, beats, gap, exp_lat(d));
            end
            if (!wr) begin
                compared++;
                if (rdata !== wl) begin
                    mismatched++;
                    $display("FAIL b2b_read[%0d] inst%0d addr %h: got %h, required %h",
                             n, d, addr, rdata, wl);
                end
            end
        end
    endtask

    task automatic test_drop();
        line_t wl, rdata;
        int lat, beats;
        bit gap;
        for (int d = 1; d < 3; d++) begin
            wl = rand_line();
            run_txn(d, 1'b0, 1'b1, 32'hC0, wl, 1'b1, rdata, lat, beats, gap);
            run_txn(d, 1'b1, 1'b0, 32'hC0, '0, 1'b1, rdata, lat, beats, gap);
            compared++;
            if (lat !== exp_lat(d) || beats !== 4 || !gap) begin
                mismatched++;
                $display("FAIL drop_shape inst%0d: lat=%0d beats=%0d gap=%b, required %0d/4/1",
                         d, lat, beats, gap, exp_lat(d));
            end
            compared++;
            if (rdata !== model[d][6]) begin
                mismatched++;
                $display("FAIL drop_data inst%0d: got %h, required %h", d, rdata, model[d][6]);
            end
        end
    endtask

    task automatic test_alias();
        line_t wl, rdata;
        int lat, beats;
        bit gap;
        wl = rand_line();
        run_txn(0, 1'b0, 1'b1, 32'h20, wl, 1'b0, rdata, lat, beats, gap);
        run_txn(0, 1'b1, 1'b0, 32'h220, '0, 1'b0, rdata, lat, beats, gap);
        compared++;
        if (rdata !== wl) begin
            mismatched++;
            $display("FAIL alias_read: got %h, required %h", rdata, wl);
        end
    endtask

    task automatic test_error();
        line_t wl, rdata;
        int lat, beats;
        bit gap, bad;
        wl = rand_line();
        run_txn(0, 1'b0, 1'b1, 32'hA0, wl, 1'b0, rdata, lat, beats, gap);
        @(negedge clk);
        read_i[0]    = 1'b1;
        write_i[0]   = 1'b1;
        address_i[0] = 32'hA0;
        burst_i[0]   = 64'hDEAD_BEEF_0BAD_F00D;
        bad = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 2) begin
                read_i[0]  = 1'b0;
                write_i[0] = 1'b0;
            end
            if (resp_o[0]) bad = 1'b1;
        end
        compared++;
        if (bad || err_o[0] !== 1'b1) begin
            mismatched++;
            $display("FAIL error_both_high: resp_seen=%b err=%b, required 0/1", bad, err_o[0]);
        end
        run_txn(0, 1'b1, 1'b0, 32'hA0, '0, 1'b0, rdata, lat, beats, gap);
        compared++;
        if (rdata !== model[0][5] || err_o[0] !== 1'b1) begin
            mismatched++;
            $display("FAIL error_sticky_unchanged: data=%h err=%b, required %h/1",
                     rdata, err_o[0], model[0][5]);
        end
    endtask

    task automatic test_reset_mid();
        line_t wl, rdata;
        int lat, beats, c;
        bit gap, hit;
        wl    = rand_line();
        c     = 0;
        beats = 0;
        hit   = 1'b0;
        @(negedge clk);
        write_i[0]   = 1'b1;
        address_i[0] = 32'h100;
        @(posedge clk);
        while (c < 100 && !hit) begin
            @(negedge clk);
            c++;
            if (resp_o[0]) begin
                write_i[0] = 1'b0;
                burst_i[0] = wl[64*beats +: 64];
                if (beats == 2) begin
                    rst = 1'b1;
                    hit = 1'b1;
                end
                beats++;
            end
        end
        @(negedge clk);
        compared++;
        if (!hit || resp_o[0] !== 1'b0 || burst_o[0] !== 64'h0 || err_o[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid_abort: reached=%b resp=%b burst=%h err=%b, required 1/0/0/0",
                     hit, resp_o[0], burst_o[0], err_o[0]);
        end
        rst = 1'b0;
        clear_model();
        run_txn(0, 1'b1, 1'b0, 32'h100, '0, 1'b0, rdata, lat, beats, gap);
        compared++;
        if (rdata !== '0 || beats !== 4) begin
            mismatched++;
            $display("FAIL reset_mid_line: got %h beats=%0d, required 0/4", rdata, beats);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            read_i[d]    = 1'b0;
            write_i[d]   = 1'b0;
            address_i[d] = '0;
            burst_i[d]   = '0;
        end
        test_reset();
        test_write_read();
        test_back_to_back();
        test_drop();
        test_alias();
        test_error();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
